// File: rtl/pic_ack_ctrl.sv
// 8259-style interrupt acknowledge controller.
// Resolves priority, runs the INTA sequence, owns ISR and EOI.
module pic_ack_ctrl #(
  parameter int NLEV     = 8,
  parameter bit AEOI_DEF = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NLEV-1:0] irr,
  input  logic [NLEV-1:0] imr,
  input  logic [4:0]      vbase,
  input  logic            aeoi_wr,
  input  logic            aeoi_val,
  input  logic            eoi,
  input  logic            eoi_sl,
  input  logic [2:0]      eoi_lvl,
  input  logic            inta,
  output logic            intr,
  output logic            freeze,
  output logic [NLEV-1:0] setzero,
  output logic [7:0]      busdata,
  output logic            en,
  output logic [NLEV-1:0] isr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK1,
    ACK2
  } state_t;

  state_t state, state_n;

  logic            inta_q;
  logic            rise, fall;
  logic            aeoi;
  logic [2:0]      lvl, lvl_n;
  logic            spur, spur_n;
  logic [NLEV-1:0] req;
  logic            pend, blk;
  logic [2:0]      win;
  logic            intr_n, freeze_n, en_n;
  logic [NLEV-1:0] setzero_n, isr_n, eoi_clr;
  logic [7:0]      busdata_n;

  assign rise = inta & ~inta_q;
  assign fall = inta_q & ~inta;
  assign req  = irr & ~imr;

  // Scan from IR0; an in-service bit stops the scan.
  always_comb begin
    pend = 1'b0;
    blk  = 1'b0;
    win  = 3'd7;
    for (int i = 0; i < NLEV; i++) begin
      if (!blk && !pend) begin
        if (isr[i]) begin
          blk = 1'b1;
        end else if (req[i]) begin
          pend = 1'b1;
          win  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    eoi_clr = '0;
    if (eoi) begin
      if (eoi_sl) eoi_clr[eoi_lvl] = 1'b1;
      else eoi_clr = isr & ~(isr - 1'b1);
    end
  end

  always_comb begin
    state_n   = state;
    intr_n    = intr;
    freeze_n  = freeze;
    en_n      = en;
    setzero_n = '0;
    busdata_n = busdata;
    lvl_n     = lvl;
    spur_n    = spur;
    isr_n     = isr & ~eoi_clr;
    unique case (state)
      IDLE: begin
        intr_n = 1'b0;
        if (pend) begin
          state_n = REQ;
          intr_n  = 1'b1;
        end
      end
      REQ: begin
        if (rise) begin
          state_n  = ACK1;
          lvl_n    = pend ? win : 3'd7;
          spur_n   = ~pend;
          freeze_n = 1'b0;
          intr_n   = 1'b0;
          // Set is applied after EOI clear so it wins.
          if (pend) begin
            setzero_n[win] = 1'b1;
            isr_n[win]     = 1'b1;
          end
        end
      end
      ACK1: begin
        if (fall) state_n = ACK2;
      end
      ACK2: begin
        if (rise) begin
          busdata_n = {vbase, lvl};
          en_n      = 1'b1;
        end
        if (fall) begin
          en_n     = 1'b0;
          freeze_n = 1'b1;
          state_n  = IDLE;
          if (aeoi && !spur) isr_n[lvl] = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      inta_q  <= 1'b0;
      aeoi    <= AEOI_DEF;
      lvl     <= 3'd0;
      spur    <= 1'b0;
      intr    <= 1'b0;
      freeze  <= 1'b1;
      setzero <= '0;
      busdata <= 8'd0;
      en      <= 1'b0;
      isr     <= '0;
    end else begin
      state   <= state_n;
      inta_q  <= inta;
      if (aeoi_wr) aeoi <= aeoi_val;
      lvl     <= lvl_n;
      spur    <= spur_n;
      intr    <= intr_n;
      freeze  <= freeze_n;
      setzero <= setzero_n;
      busdata <= busdata_n;
      en      <= en_n;
      isr     <= isr_n;
    end
  end

endmodule

// File: tb/tb_pic_ack_ctrl.sv
// Bench for pic_ack_ctrl: directed steps plus randomized
// requests checked against a priority/ISR reference model.
module tb_pic_ack_ctrl;

  logic       clk, rst;
  logic [7:0] irr, imr;
  logic [4:0] vbase;
  logic       aeoi_wr, aeoi_val;
  logic       eoi, eoi_sl;
  logic [2:0] eoi_lvl;
  logic       inta;
  logic       intr, freeze, en;
  logic [7:0] setzero, busdata, isr;

  int nerr = 0;
  int nchk = 0;

  logic [7:0] m_isr;
  bit         m_aeoi;
  logic [4:0] vb;

  pic_ack_ctrl #(.NLEV(8), .AEOI_DEF(1'b0)) dut (
    .clk(clk), .rst(rst), .irr(irr), .imr(imr),
    .vbase(vbase), .aeoi_wr(aeoi_wr), .aeoi_val(aeoi_val),
    .eoi(eoi), .eoi_sl(eoi_sl), .eoi_lvl(eoi_lvl),
    .inta(inta), .intr(intr), .freeze(freeze),
    .setzero(setzero), .busdata(busdata), .en(en),
    .isr(isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowbit(input logic [7:0] x);
    logic [7:0] t;
    t = x & (~x + 8'd1);
    return $clog2(t);
  endfunction

  // Fully nested: lowest request wins unless an ISR bit at
  // or above its priority is set.
  function automatic int winner(input logic [7:0] r,
                                input logic [7:0] s);
    if (r == 8'd0) return -1;
    if (s != 8'd0 && lowbit(s) <= lowbit(r)) return -1;
    return lowbit(r);
  endfunction

  function automatic logic [7:0] eoi_apply(input logic [7:0] s,
                                           input bit sl,
                                           input logic [2:0] lv);
    if (sl) s[lv] = 1'b0;
    else if (s != 8'd0) s[lowbit(s)] = 1'b0;
    return s;
  endfunction

  task automatic ack_cycle(input bit eo, input bit esl,
                           input logic [2:0] elv);
    int         w;
    bit         sp;
    logic [2:0] l;
    logic [7:0] sz;
    w  = winner(irr & ~imr, m_isr);
    sp = (w < 0);
    l  = sp ? 3'd7 : 3'(w);
    inta = 1'b1;
    eoi = eo; eoi_sl = esl; eoi_lvl = elv;
    tick();
    eoi = 1'b0;
    irr = 8'd0;
    if (eo) m_isr = eoi_apply(m_isr, esl, elv);
    sz = 8'd0;
    if (!sp) begin
      sz[l] = 1'b1;
      m_isr[l] = 1'b1;
    end
    chk("ack1_intr", {7'd0, intr}, 8'd0);
    chk("ack1_freeze", {7'd0, freeze}, 8'd0);
    chk("ack1_setzero", setzero, sz);
    chk("ack1_isr", isr, m_isr);
    tick();
    chk("setzero_pulse", setzero, 8'd0);
    inta = 1'b0;
    tick();
    chk("ack1_en", {7'd0, en}, 8'd0);
    chk("ack1_freeze_low", {7'd0, freeze}, 8'd0);
    inta = 1'b1;
    tick();
    chk("ack2_en", {7'd0, en}, 8'd1);
    chk("ack2_vec", busdata, {vb, l});
    chk("ack2_freeze", {7'd0, freeze}, 8'd0);
    tick();
    chk("ack2_en_hold", {7'd0, en}, 8'd1);
    inta = 1'b0;
    tick();
    if (m_aeoi && !sp) m_isr[l] = 1'b0;
    chk("ack2_en_off", {7'd0, en}, 8'd0);
    chk("ack2_freeze_hi", {7'd0, freeze}, 8'd1);
    chk("ack2_bus_hold", busdata, {vb, l});
    chk("ack2_isr", isr, m_isr);
    chk("ack2_intr", {7'd0, intr}, 8'd0);
  endtask

  task automatic eoi_cmd(input bit sl, input logic [2:0] lv);
    eoi = 1'b1; eoi_sl = sl; eoi_lvl = lv;
    tick();
    eoi = 1'b0;
    m_isr = eoi_apply(m_isr, sl, lv);
    chk("eoi_isr", isr, m_isr);
  endtask

  initial begin
    int w;
    rst = 1'b1; irr = 8'd0; imr = 8'd0; vb = 5'h08; vbase = vb;
    aeoi_wr = 1'b0; aeoi_val = 1'b0; eoi = 1'b0; eoi_sl = 1'b0;
    eoi_lvl = 3'd0; inta = 1'b0;
    m_isr = 8'd0; m_aeoi = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_intr", {7'd0, intr}, 8'd0);
    chk("rst_freeze", {7'd0, freeze}, 8'd1);
    chk("rst_isr", isr, 8'd0);
    chk("rst_en", {7'd0, en}, 8'd0);
    chk("rst_setzero", setzero, 8'd0);
    chk("rst_bus", busdata, 8'd0);

    irr = 8'h24;
    chk("pre_intr", {7'd0, intr}, 8'd0);
    tick();
    chk("intr_lat", {7'd0, intr}, 8'd1);
    ack_cycle(1'b0, 1'b0, 3'd0);
    chk("ir2_isr", isr, 8'h04);

    irr = 8'h08;
    tick(); tick();
    chk("blocked_intr", {7'd0, intr}, 8'd0);
    irr = 8'h01;
    tick();
    chk("nest_intr", {7'd0, intr}, 8'd1);
    ack_cycle(1'b0, 1'b0, 3'd0);
    chk("nest_isr", isr, 8'h05);
    eoi_cmd(1'b0, 3'd0);
    chk("ns_eoi", isr, 8'h04);
    eoi_cmd(1'b1, 3'd2);

    irr = 8'h10;
    tick();
    chk("sp_intr", {7'd0, intr}, 8'd1);
    irr = 8'h00;
    tick();
    chk("sp_intr_hold", {7'd0, intr}, 8'd1);
    ack_cycle(1'b0, 1'b0, 3'd0);
    chk("sp_isr", isr, 8'h00);

    aeoi_wr = 1'b1; aeoi_val = 1'b1;
    tick();
    aeoi_wr = 1'b0; m_aeoi = 1'b1;
    irr = 8'h08;
    tick();
    chk("aeoi_intr", {7'd0, intr}, 8'd1);
    ack_cycle(1'b0, 1'b0, 3'd0);
    chk("aeoi_isr", isr, 8'h00);
    irr = 8'h08;
    tick();
    chk("same_intr", {7'd0, intr}, 8'd1);
    ack_cycle(1'b1, 1'b1, 3'd3);
    aeoi_wr = 1'b1; aeoi_val = 1'b0;
    tick();
    aeoi_wr = 1'b0; m_aeoi = 1'b0;

    for (int k = 0; k < 24; k++) begin
      vb = 5'($urandom); vbase = vb;
      irr = 8'($urandom);
      imr = 8'($urandom);
      tick();
      w = winner(irr & ~imr, m_isr);
      chk("rnd_intr", {7'd0, intr}, {7'd0, w >= 0});
      if (w >= 0) begin
        ack_cycle(1'($urandom), 1'($urandom), 3'($urandom));
      end else begin
        irr = 8'd0;
        tick();
      end
      irr = 8'd0;
      if ($urandom_range(1) == 1)
        eoi_cmd(1'($urandom), 3'($urandom));
    end

    imr = 8'd0;
    for (int k = 0; k < 8; k++) eoi_cmd(1'b0, 3'd0);
    irr = 8'h02;
    tick();
    chk("r_intr", {7'd0, intr}, 8'd1);
    inta = 1'b1;
    tick();
    chk("r_isr_set", isr, 8'h02);
    irr = 8'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_isr = 8'd0;
    chk("r_freeze", {7'd0, freeze}, 8'd1);
    chk("r_isr", isr, 8'd0);
    chk("r_intr0", {7'd0, intr}, 8'd0);
    chk("r_setzero", setzero, 8'd0);
    inta = 1'b0;
    tick();
    inta = 1'b1;
    tick(); tick();
    chk("r_ign_en", {7'd0, en}, 8'd0);
    chk("r_ign_isr", isr, 8'd0);
    chk("r_ign_frz", {7'd0, freeze}, 8'd1);
    inta = 1'b0;
    tick(); tick();
    chk("r_ign_intr", {7'd0, intr}, 8'd0);
    chk("r_ign_en2", {7'd0, en}, 8'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pic_ack_ctrl.md
Name: pic_ack_ctrl

Overview:
Interrupt acknowledge controller for the 8259-style PIC. It resolves the highest-priority unmasked request from the IRR outputs and raises INTR. It then runs the two-pulse INTA sequence, maintaining the in-service register (ISR) and driving the vector onto the data bus. It also generates the IRR freeze and per-bit clear (setzero) controls and handles EOI commands.

Parameters:
NLEV, 8, number of interrupt levels (fixed at 8; vector encoding assumes 3 bits)
AEOI_DEF, 0, reset value of the auto-EOI mode bit

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
irr  in  8  IRR contents (bit 0 = IR0)
imr  in  8  interrupt mask register (1 = masked)
vbase  in  5  vector base T7..T3 from ICW2
aeoi_wr  in  1  one-cycle strobe loading aeoi_val
aeoi_val  in  1  auto-EOI mode value
eoi  in  1  one-cycle EOI command strobe
eoi_sl  in  1  1 = specific EOI, 0 = non-specific
eoi_lvl  in  3  level cleared on specific EOI
inta  in  1  interrupt acknowledge, active-high level, ≥1 cycle high and ≥1 cycle low per pulse
intr  out  1  interrupt request to CPU
freeze  out  8→1  1 = IRR tracks inputs, 0 = IRR held
setzero  out  8  one-cycle per-bit IRR sense-latch clear
busdata  out  8  vector byte
en  out  1  bus drive enable for busdata
isr  out  8  in-service register

Behaviour:
- Reset (clk edge with rst=1): state IDLE, intr=0, freeze=1, setzero=0, busdata=0, en=0, isr=0, aeoi=AEOI_DEF, inta edge register=0. Reset mid-sequence aborts it; nothing is retained.
- Rising edge of inta is detected via a registered copy (inta & ~inta_q). Falling edge is inta_q & ~inta.
- Priority is fully nested; IR0 is highest.
  - req = irr & ~imr.
  - Winner = lowest index i with req[i]=1 and isr[0..i]=0.
  - pend = a winner exists.
- FSM states: IDLE, REQ, ACK1, ACK2.
- IDLE: intr=0. If pend, go to REQ (intr=1 the next cycle; 1-cycle latency). inta edges are ignored in IDLE.
- REQ: intr=1, held regardless of pend changes. On an inta rising edge:
  - Latch winner level L (if no winner: L=7, spurious=1).
  - freeze=0, intr=0.
  - If not spurious: isr[L]=1 and setzero[L]=1 for exactly that one cycle.
  - Go to ACK1.
- ACK1: waits for the inta falling edge, then goes to ACK2. freeze stays 0.
- ACK2: on the inta rising edge:
  - busdata={vbase,L}; en=1 from the following cycle while inta stays high.
  - On the inta falling edge: en=0, freeze=1.
  - If aeoi=1 and not spurious, isr[L] clears on that falling-edge cycle.
  - Return to IDLE.
- busdata holds its last value when en=0.
- EOI (accepted in any state):
  - Non-specific: clears the lowest-index set isr bit; no-op if isr=0.
  - Specific: clears isr[eoi_lvl].
  - Same cycle as an ACK set of the same bit: set wins. Different bits: both apply.
- aeoi_wr updates aeoi on the next cycle; the mode in effect at the ACK2 falling edge governs.
- Masked, or blocked by an equal/higher ISR bit: pend=0. A lower-priority in-service bit does not block.
- Request withdrawn between intr and first INTA: spurious path, vector {vbase,3'b111}, isr unchanged, setzero=0.
- setzero is never asserted outside the ACK1 entry cycle.

Test Plan:
- rst=1 for 2 cycles, then irr=0 -> intr=0, freeze=1, isr=0, en=0, setzero=0.
- vbase=5'h08, irr=8'h24, imr=0; two INTA pulses -> intr at cycle+1; isr=8'h04, setzero=8'h04 one cycle; busdata=8'h42 with en=1 during second INTA; freeze=0 from first INTA rise to second INTA fall.
- isr=8'h04 in service, irr=8'h08 -> intr stays 0. irr=8'h01 -> intr=1; after ack isr=8'h05. Non-specific eoi -> isr=8'h04.
- irr=8'h10, intr=1; drop irr before first INTA -> vector {vbase,3'b111}, isr unchanged, setzero=0.
- aeoi_val=1 via aeoi_wr; ack IR3 -> isr[3] set after first INTA, 0 after second INTA fall. Specific eoi_lvl=3 in the same cycle as an ack of IR3 -> isr[3]=1.
- Assert rst during ACK1 -> next cycle IDLE, freeze=1, isr=0, intr=0; a later INTA without intr is ignored.
